uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: oversampled start/data/parity/stop decoding
// with 2-of-3 majority voting and one-cycle status pulses.
module uart_rx_frame_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 5);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic [1:0]            smp_q, smp_d;
    logic                  bit_val_q, bit_val_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_W-1:0]     p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  sg_q, sg_d;
    logic                  busy_q, busy_d;

    logic [PRESCALE_W-1:0] p_even_c, p_eff_c, half_c;
    logic [BIT_CNT_W-1:0]  last_stop_c;
    logic                  maj_c, at_dec_c, at_act_c, wrap_c;

    // Effective bit period: even, never below 8
    assign p_even_c = prescale & ~PRESCALE_W'(1);
    assign p_eff_c  = (p_even_c < P_MIN) ? P_MIN : p_even_c;
    assign half_c   = p_q >> 1;

    assign at_dec_c = (edge_q == half_c + PRESCALE_W'(1));
    assign at_act_c = (edge_q == half_c + PRESCALE_W'(2));
    assign wrap_c   = (edge_q == p_q - PRESCALE_W'(1));
    assign maj_c    = (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);

    // Frame-wide bit index of the final stop bit (start bit is index 0)
    assign last_stop_c = BIT_CNT_W'(DATA_W + 1) + BIT_CNT_W'(par_en_q) + BIT_CNT_W'(stop2_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_q       <= P_MIN;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            smp_q     <= '0;
            bit_val_q <= 1'b0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            sg_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            p_q       <= p_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            smp_q     <= smp_d;
            bit_val_q <= bit_val_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
            sg_q      <= sg_d;
            busy_q    <= busy_d;
        end
    end

    // Pulses are computed one edge early so they appear registered at edge P/2+2
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        p_d       = p_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        smp_d     = smp_q;
        bit_val_d = bit_val_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        sg_d      = 1'b0;

        if (state_q != IDLE) begin
            edge_d = wrap_c ? '0 : edge_q + PRESCALE_W'(1);
            if (wrap_c) begin
                bit_d = bit_q + BIT_CNT_W'(1);
            end
            if (edge_q == half_c - PRESCALE_W'(1)) begin
                smp_d[0] = RX_IN;
            end
            if (edge_q == half_c) begin
                smp_d[1] = RX_IN;
            end
            if (at_dec_c) begin
                bit_val_d = maj_c;
            end
        end

        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!RX_IN) begin
                    state_d   = START;
                    edge_d    = PRESCALE_W'(1);
                    p_d       = p_eff_c;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    ferr_d    = 1'b0;
                end
            end
            START: begin
                if (at_dec_c && maj_c) begin
                    sg_d = 1'b1;
                end
                if (at_act_c && bit_val_q) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (wrap_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_dec_c) begin
                    shift_d = {maj_c, shift_q[DATA_W-1:1]};
                end
                if (wrap_c && (bit_q == BIT_CNT_W'(DATA_W))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_dec_c && (maj_c != (^shift_q ^ par_typ_q))) begin
                    pe_d   = 1'b1;
                    ferr_d = 1'b1;
                end
                if (wrap_c) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_dec_c && !maj_c) begin
                    se_d   = 1'b1;
                    ferr_d = 1'b1;
                end
                if (wrap_c && (bit_q == last_stop_c)) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                    if (!ferr_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign P_DATA      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = pe_q;
    assign stp_err     = se_q;
    assign strt_glitch = sg_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed self-checking bench for uart_rx_frame_ctrl (DATA_W=8).
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [5:0] prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int p_cyc = 8;

    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, sg_cnt = 0, multi_cnt = 0;
    int dv_cyc = 0, dv_prev_cyc = 0, pe_cyc = 0, se_cyc = 0, sg_cyc = 0;
    logic [7:0] dv_data = 8'h00, dv_prev_data = 8'h00;

    uart_rx_frame_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .prescale   (prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .strt_glitch(strt_glitch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (data_valid) begin
            dv_prev_cyc  = dv_cyc;
            dv_prev_data = dv_data;
            dv_cyc       = cyc;
            dv_data      = P_DATA;
            dv_cnt++;
        end
        if (par_err)     begin pe_cyc = cyc; pe_cnt++; end
        if (stp_err)     begin se_cyc = cyc; se_cnt++; end
        if (strt_glitch) begin sg_cyc = cyc; sg_cnt++; end
        if ((32'(data_valid) + 32'(par_err) + 32'(stp_err) + 32'(strt_glitch)) > 32'd1)
            multi_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int errs();
        return pe_cnt + se_cnt + sg_cnt;
    endfunction

    // Drives one frame from the current negedge; returns the cycle of start edge 0
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic s2, input logic flip_par, input logic zero_stop2,
                              input int toggle_at, output int start_cyc);
        logic [15:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i]; n++;
        end
        if (pe) begin
            bits[n] = (^d) ^ pt ^ flip_par; n++;
        end
        bits[n] = 1'b1; n++;
        if (s2) begin
            bits[n] = ~zero_stop2; n++;
        end
        PAR_EN    = pe;
        PAR_TYP   = pt;
        STOP2     = s2;
        start_cyc = cyc;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p_cyc; c++) begin
                if (toggle_at == b * p_cyc + c) PAR_EN = ~PAR_EN;
                if (b == 0 && c == 1) check_eq("busy_in_frame", 32'(busy), 32'd1);
                RX_IN = bits[b];
                @(negedge clk);
            end
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        int s, s2c, b_dv, b_err, b_pe, b_se, b_sg;
        rst_n    = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        STOP2    = 1'b0;
        prescale = 6'd8;
        p_cyc    = 8;
        repeat (3) @(negedge clk);
        check_eq("rst_p_data", 32'(P_DATA), 32'h0);
        check_eq("rst_dv", 32'(data_valid), 32'd0);
        check_eq("rst_par_err", 32'(par_err), 32'd0);
        check_eq("rst_stp_err", 32'(stp_err), 32'd0);
        check_eq("rst_glitch", 32'(strt_glitch), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // Good frame 0xA5, even parity; start edge lands on the first edge out of reset
        rst_n = 1'b1;
        b_dv = dv_cnt; b_err = errs();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
        repeat (4) @(negedge clk);
        check_eq("a_dv_count", 32'(dv_cnt - b_dv), 32'd1);
        check_eq("a_dv_cycle", 32'(dv_cyc - s), 32'd88);
        check_eq("a_dv_data", 32'(dv_data), 32'hA5);
        check_eq("a_p_data", 32'(P_DATA), 32'hA5);
        check_eq("a_no_errors", 32'(errs() - b_err), 32'd0);
        check_eq("a_busy_idle", 32'(busy), 32'd0);

        // Inverted parity bit
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; b_sg = sg_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, s);
        repeat (4) @(negedge clk);
        check_eq("b_pe_count", 32'(pe_cnt - b_pe), 32'd1);
        check_eq("b_pe_cycle", 32'(pe_cyc - s), 32'd78);
        check_eq("b_no_dv", 32'(dv_cnt - b_dv), 32'd0);
        check_eq("b_p_data_held", 32'(P_DATA), 32'hA5);
        check_eq("b_no_other_err", 32'((se_cnt - b_se) + (sg_cnt - b_sg)), 32'd0);

        // False start: low for 3 cycles with prescale 16
        prescale = 6'd16;
        p_cyc    = 16;
        b_dv = dv_cnt; b_sg = sg_cnt;
        s = cyc;
        RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        RX_IN = 1'b1;
        repeat (7) @(negedge clk);
        check_eq("c_glitch_at_10", 32'(strt_glitch), 32'd1);
        check_eq("c_busy_at_10", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("c_busy_at_11", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("c_sg_count", 32'(sg_cnt - b_sg), 32'd1);
        check_eq("c_sg_cycle", 32'(sg_cyc - s), 32'd10);
        check_eq("c_no_dv", 32'(dv_cnt - b_dv), 32'd0);

        // Two stop bits, second one low
        prescale = 6'd8;
        p_cyc    = 8;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1, s);
        repeat (4) @(negedge clk);
        check_eq("d_se_count", 32'(se_cnt - b_se), 32'd1);
        check_eq("d_se_cycle", 32'(se_cyc - s), 32'd94);
        check_eq("d_no_dv", 32'(dv_cnt - b_dv), 32'd0);
        check_eq("d_no_pe", 32'(pe_cnt - b_pe), 32'd0);
        check_eq("d_p_data_held", 32'(P_DATA), 32'hA5);

        // Back-to-back frames
        b_dv = dv_cnt; b_err = errs();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, s2c);
        repeat (4) @(negedge clk);
        check_eq("e_dv_count", 32'(dv_cnt - b_dv), 32'd2);
        check_eq("e_first_data", 32'(dv_prev_data), 32'h55);
        check_eq("e_second_data", 32'(dv_data), 32'hAA);
        check_eq("e_first_cycle", 32'(dv_prev_cyc - s), 32'd88);
        check_eq("e_dv_spacing", 32'(dv_cyc - dv_prev_cyc), 32'd88);
        check_eq("e_no_errors", 32'(errs() - b_err), 32'd0);

        // PAR_EN toggled mid-frame must be ignored
        b_dv = dv_cnt; b_err = errs();
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, s);
        PAR_EN = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("f_dv_count", 32'(dv_cnt - b_dv), 32'd1);
        check_eq("f_dv_cycle", 32'(dv_cyc - s), 32'd80);
        check_eq("f_dv_data", 32'(dv_data), 32'h96);
        check_eq("f_no_errors", 32'(errs() - b_err), 32'd0);

        // Reset in the middle of a frame
        b_dv = dv_cnt; b_err = errs();
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        RX_IN = 1'b1;
        repeat (22) @(negedge clk);
        check_eq("g_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("g_rst_p_data", 32'(P_DATA), 32'h0);
        check_eq("g_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("g_no_dv", 32'(dv_cnt - b_dv), 32'd0);
        check_eq("g_no_errors", 32'(errs() - b_err), 32'd0);
        check_eq("g_p_data_zero", 32'(P_DATA), 32'h0);

        // Clean frame after reset; odd parity, prescale 9 behaves as 8
        prescale = 6'd9;
        b_dv = dv_cnt; b_err = errs();
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, s);
        repeat (4) @(negedge clk);
        check_eq("h_dv_count", 32'(dv_cnt - b_dv), 32'd1);
        check_eq("h_dv_cycle", 32'(dv_cyc - s), 32'd88);
        check_eq("h_dv_data", 32'(P_DATA), 32'hC3);
        check_eq("h_no_errors", 32'(errs() - b_err), 32'd0);

        // Prescale below 8 clamps to 8; no parity, two good stop bits
        prescale = 6'd2;
        b_dv = dv_cnt; b_err = errs();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
        repeat (4) @(negedge clk);
        check_eq("i_dv_count", 32'(dv_cnt - b_dv), 32'd1);
        check_eq("i_dv_cycle", 32'(dv_cyc - s), 32'd88);
        check_eq("i_dv_data", 32'(P_DATA), 32'h3C);
        check_eq("i_no_errors", 32'(errs() - b_err), 32'd0);

        check_eq("pulse_overlap", 32'(multi_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
